score_counter: RTL and testbench

SCORE_COUNTER -- requirements
Module: score_counter

---
 rtl/score_counter_pkg.sv | 33 +++
 rtl/score_counter_if.sv | 27 ++
 rtl/score_counter_bcd_digit.sv | 34 +++
 rtl/score_counter.sv | 100 ++++++++++
 tb/tb_score_counter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_counter_pkg.sv
// Shared game-control definitions for the score counter: FSM states, BCD limits
// and the packed six-digit score type with its magnitude comparator.
package score_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_e;

   localparam logic [3:0]  BCD_MAX      = 4'd9;
   localparam int unsigned SCORE_DIGITS = 6;

   typedef logic [4*SCORE_DIGITS-1:0] score_t;

   // Most significant differing digit decides; equal scores are not greater.
   function automatic logic score_gt(input score_t a, input score_t b);
      logic gt;
      logic decided;
      int unsigned k;
      gt      = 1'b0;
      decided = 1'b0;
      for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
         k = SCORE_DIGITS - 1 - i;
         if (!decided && (a[4*k +: 4] != b[4*k +: 4])) begin
            gt      = a[4*k +: 4] > b[4*k +: 4];
            decided = 1'b1;
         end
      end
      return gt;
   endfunction

endpackage

// File: rtl/score_counter_if.sv
// Control inputs and display outputs of the score counter, grouped as one bus.
interface score_counter_if;

   logic       start;
   logic       collision;
   logic       score_tick;
   logic       show_high;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic [3:0] digit4;
   logic [3:0] digit5;
   logic       running;
   logic       new_high;

   modport master (
      output start, collision, score_tick, show_high,
      input  digit0, digit1, digit2, digit3, digit4, digit5, running, new_high
   );

   modport slave (
      input  start, collision, score_tick, show_high,
      output digit0, digit1, digit2, digit3, digit4, digit5, running, new_high
   );

endinterface

// File: rtl/score_counter_bcd_digit.sv
// One BCD score digit: synchronous clear, increment on carry-in, hold when the
// whole score is saturated, ripple carry-out when wrapping from 9.
module bcd_digit
   import score_counter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr_i,
   input  logic       carry_i,
   input  logic       sat_i,
   output logic [3:0] val_o,
   output logic       carry_o
);

   logic [3:0] val_q, val_d;

   always_comb begin
      val_d = val_q;
      if (clr_i) begin
         val_d = '0;
      end else if (carry_i && !sat_i) begin
         val_d = (val_q == BCD_MAX) ? '0 : val_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) val_q <= '0;
      else       val_q <= val_d;
   end

   assign val_o   = val_q;
   assign carry_o = carry_i && (val_q == BCD_MAX);

endmodule

// File: rtl/score_counter.sv
// Game score counter: IDLE/RUN/OVER control, tick prescaler, six-digit BCD
// score with saturation, high-score capture and a display mux.
module score_counter
   import score_counter_pkg::*;
#(
   parameter int unsigned TICK_DIV = 6
) (
   input  logic            clk,
   input  logic            reset,
   score_counter_if.slave  bus
);

   localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

   state_e  state_q, state_d;
   logic [7:0] presc_q, presc_d;
   score_t  high_q, high_d;
   logic    new_high_q, new_high_d;

   score_t  score;
   score_t  shown;
   logic [SCORE_DIGITS:0] carry;
   logic    clr_score;
   logic    inc;

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      high_d     = high_q;
      new_high_d = 1'b0;
      clr_score  = 1'b0;
      inc        = 1'b0;
      unique case (state_q)
         IDLE, OVER: begin
            if (bus.start) begin
               state_d   = RUN;
               presc_d   = '0;
               clr_score = 1'b1;
            end
         end
         RUN: begin
            if (bus.collision) begin
               state_d = OVER;
               if (score_gt(score, high_q)) begin
                  high_d     = score;
                  new_high_d = 1'b1;
               end
            end else if (bus.score_tick) begin
               if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  inc     = 1'b1;
               end else begin
                  presc_d = presc_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         high_q     <= '0;
         new_high_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         high_q     <= high_d;
         new_high_q <= new_high_d;
      end
   end

   // A carry out of the top digit means 999999 is already held: block all digits.
   assign carry[0] = inc;

   for (genvar i = 0; i < SCORE_DIGITS; i++) begin : g_dig
      bcd_digit u_dig (
         .clk     (clk),
         .reset   (reset),
         .clr_i   (clr_score),
         .carry_i (carry[i]),
         .sat_i   (carry[SCORE_DIGITS]),
         .val_o   (score[4*i +: 4]),
         .carry_o (carry[i+1])
      );
   end

   assign shown        = bus.show_high ? high_q : score;
   assign bus.digit0   = shown[3:0];
   assign bus.digit1   = shown[7:4];
   assign bus.digit2   = shown[11:8];
   assign bus.digit3   = shown[15:12];
   assign bus.digit4   = shown[19:16];
   assign bus.digit5   = shown[23:20];
   assign bus.running  = (state_q == RUN);
   assign bus.new_high = new_high_q;

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: directed vector table, hand-written
// corner sequences and randomized play against an arithmetic reference model.
module tb_score_counter;

   localparam int TDIV = 6;

   logic clk;
   logic reset;

   score_counter_if bus ();

   score_counter #(.TICK_DIV(TDIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // Reference model: plain integers, a running flag and a tick counter.
   int m_score;
   int m_high;
   int m_ticks;
   bit m_running;
   bit m_newhigh;

   typedef struct {
      logic s;
      logic c;
      logic t;
      logic h;
      int   digits;
      logic run;
      logic nh;
   } vec_t;

   vec_t tbl[$];

   function automatic int shown_val();
      return int'(bus.digit0) + 10 * int'(bus.digit1) + 100 * int'(bus.digit2)
           + 1000 * int'(bus.digit3) + 10000 * int'(bus.digit4)
           + 100000 * int'(bus.digit5);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_score   = 0;
      m_high    = 0;
      m_ticks   = 0;
      m_running = 0;
      m_newhigh = 0;
   endtask

   task automatic model_step(input bit s, input bit c, input bit t);
      m_newhigh = 0;
      if (!m_running) begin
         if (s) begin
            m_running = 1;
            m_score   = 0;
            m_ticks   = 0;
         end
      end else if (c) begin
         m_running = 0;
         if (m_score > m_high) begin
            m_high    = m_score;
            m_newhigh = 1;
         end
      end else if (t) begin
         m_ticks++;
         if (m_ticks == TDIV) begin
            m_ticks = 0;
            if (m_score < 999999) m_score++;
         end
      end
   endtask

   task automatic step(input logic s, input logic c, input logic t, input logic h);
      bus.start      = s;
      bus.collision  = c;
      bus.score_tick = t;
      bus.show_high  = h;
      @(posedge clk);
      model_step(s, c, t);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      bus.start      = 1'b0;
      bus.collision  = 1'b0;
      bus.score_tick = 1'b0;
      bus.show_high  = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   function automatic void add(input logic s, input logic c, input logic t, input logic h,
                               input int d, input logic r, input logic nh);
      vec_t v;
      v.s = s; v.c = c; v.t = t; v.h = h;
      v.digits = d; v.run = r; v.nh = nh;
      tbl.push_back(v);
   endfunction

   initial begin
      n_vec = 0;
      n_err = 0;
      model_reset();

      //  s  c  t  h  digits run nh
      add(1, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 1, 0);
      add(0, 0, 1, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 1, 0);
      add(0, 0, 1, 1, 0, 1, 0);
      add(0, 1, 0, 0, 1, 0, 1);
      add(0, 0, 0, 1, 1, 0, 0);
      add(0, 0, 1, 0, 1, 0, 0);
      add(0, 1, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, 0, 0);

      // Reset state
      do_reset();
      chk("reset_digits", shown_val(), 0);
      chk("reset_running", int'(bus.running), 0);
      chk("reset_new_high", int'(bus.new_high), 0);

      // Directed vector table
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].s, tbl[i].c, tbl[i].t, tbl[i].h);
         chk($sformatf("tbl%0d_digits", i), shown_val(), tbl[i].digits);
         chk($sformatf("tbl%0d_running", i), int'(bus.running), int'(tbl[i].run));
         chk($sformatf("tbl%0d_new_high", i), int'(bus.new_high), int'(tbl[i].nh));
      end

      // Twelve ticks give two increments
      do_reset();
      step(1, 0, 0, 0);
      ticks(11);
      chk("tick11_digits", shown_val(), 1);
      ticks(1);
      chk("tick12_digits", shown_val(), 2);
      chk("tick12_running", int'(bus.running), 1);

      // Multi-digit carry 000999 -> 001000
      ticks((999 - 2) * TDIV);
      chk("score_999", shown_val(), 999);
      ticks(TDIV - 1);
      chk("score_999_hold", shown_val(), 999);
      ticks(1);
      chk("score_1000", shown_val(), 1000);

      // High-score update and non-update
      do_reset();
      step(1, 0, 0, 0);
      ticks(100 * TDIV);
      step(0, 1, 0, 0);
      chk("hs100_new_high", int'(bus.new_high), 1);
      step(1, 0, 0, 0);
      chk("hs_pulse_one_cycle", int'(bus.new_high), 0);
      ticks(150 * TDIV);
      chk("score_150", shown_val(), 150);
      step(0, 1, 0, 0);
      chk("hs150_new_high", int'(bus.new_high), 1);
      chk("hs150_running", int'(bus.running), 0);
      chk("hs150_score", shown_val(), 150);
      step(0, 0, 0, 1);
      chk("hs150_pulse_end", int'(bus.new_high), 0);
      chk("hs150_high", shown_val(), 150);
      step(1, 0, 0, 0);
      ticks(90 * TDIV);
      step(0, 1, 0, 0);
      chk("hs90_no_new_high", int'(bus.new_high), 0);
      chk("hs90_score", shown_val(), 90);
      step(0, 0, 0, 1);
      chk("hs90_high_kept", shown_val(), 150);
      chk("hs90_no_pulse_late", int'(bus.new_high), 0);

      // Collision beats a qualifying tick
      step(1, 0, 0, 0);
      ticks(41 * TDIV + TDIV - 1);
      chk("pre_coll_41", shown_val(), 41);
      step(0, 1, 1, 0);
      chk("coll_tick_score", shown_val(), 41);
      chk("coll_tick_running", int'(bus.running), 0);
      ticks(2 * TDIV);
      chk("over_ignores_ticks", shown_val(), 41);

      // Asynchronous reset mid-game
      do_reset();
      step(1, 0, 0, 0);
      ticks(10 * TDIV);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      ticks(77 * TDIV);
      chk("pre_reset_77", shown_val(), 77);
      reset = 1'b1;
      #1;
      chk("async_reset_digits", shown_val(), 0);
      chk("async_reset_running", int'(bus.running), 0);
      chk("async_reset_new_high", int'(bus.new_high), 0);
      bus.show_high = 1'b1;
      #1;
      chk("async_reset_high", shown_val(), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      ticks(3 * TDIV);
      step(0, 1, 0, 0);
      chk("post_reset_idle_score", shown_val(), 0);
      chk("post_reset_idle_running", int'(bus.running), 0);
      step(0, 0, 0, 1);
      chk("post_reset_high", shown_val(), 0);

      // Saturation at 999999 (digits preloaded while holding in RUN)
      step(1, 0, 0, 0);
      force dut.g_dig[0].u_dig.val_q = 4'd9;
      force dut.g_dig[1].u_dig.val_q = 4'd9;
      force dut.g_dig[2].u_dig.val_q = 4'd9;
      force dut.g_dig[3].u_dig.val_q = 4'd9;
      force dut.g_dig[4].u_dig.val_q = 4'd9;
      force dut.g_dig[5].u_dig.val_q = 4'd9;
      step(0, 0, 0, 0);
      release dut.g_dig[0].u_dig.val_q;
      release dut.g_dig[1].u_dig.val_q;
      release dut.g_dig[2].u_dig.val_q;
      release dut.g_dig[3].u_dig.val_q;
      release dut.g_dig[4].u_dig.val_q;
      release dut.g_dig[5].u_dig.val_q;
      step(0, 0, 0, 0);
      chk("sat_preload", shown_val(), 999999);
      for (int k = 0; k < 3; k++) begin
         ticks(TDIV);
         chk($sformatf("sat_hold%0d", k), shown_val(), 999999);
      end
      step(0, 1, 0, 0);
      chk("sat_new_high", int'(bus.new_high), 1);

      // Randomized play against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic s, c, t, h;
         int v;
         s = ($urandom_range(0, 39) == 0);
         c = ($urandom_range(0, 59) == 0);
         t = 1'($urandom_range(0, 1));
         h = ($urandom_range(0, 7) == 0);
         step(s, c, t, h);
         v = h ? m_high : m_score;
         chk($sformatf("rnd%0d_digits", i), shown_val(), v);
         chk($sformatf("rnd%0d_running", i), int'(bus.running), int'(m_running));
         chk($sformatf("rnd%0d_new_high", i), int'(bus.new_high), int'(m_newhigh));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
